// File: rtl/fixdiv_pkg.sv
// Shared types and constants for the fixdiv17 sequential fixed-point divider.
package fixdiv_pkg;

  // Operand geometry: 17-bit dividend/quotient, Q1.7 divisor.
  localparam int DW   = 17;
  localparam int CW   = 8;
  localparam int FRAC = 7;

  // Pre-shifted numerator width and the step counter that walks it.
  localparam int NW   = DW + FRAC;
  localparam int CNTW = $clog2(NW);

  // Saturation magnitudes, sized to the rounded-magnitude datapath (NW+1 bits).
  localparam logic [NW:0] POS_MAX = {{(NW + 1 - DW){1'b0}}, 1'b0, {(DW - 1){1'b1}}};
  localparam logic [NW:0] NEG_MAG = {{(NW + 1 - DW){1'b0}}, 1'b1, {(DW - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fixdiv17_sign_mag.sv
// sign_mag: combinational two's-complement to sign/magnitude split.
// The magnitude is W bits unsigned, so the most negative input maps to 2^(W-1)
// without wrapping.
module sign_mag #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  output logic         sign,
  output logic [W-1:0] mag
);

  // Negate negative inputs; the unsigned result covers 2^(W-1).
  always_comb begin
    sign = value[W-1];
    mag  = value[W-1] ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/fixdiv17.sv
// fixdiv17: sequential restoring divider, quotient = trunc(dividend * 2^FRAC / divisor),
// saturated to the 17-bit two's-complement range, with divide-by-zero flagging.
// One division in flight; valid/ready handshakes on both sides.
// Optional build macro FIXDIV_ROUND_EN: round half away from zero instead of
// truncating toward zero (same latency).
module fixdiv17
  import fixdiv_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [CW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic          ovf,
  output logic          dz
);

  state_t state_reg, state_next;

  logic            sign_a, sign_b;
  logic [DW-1:0]   mag_a;
  logic [CW-1:0]   mag_b;

  logic [NW-1:0]   num_reg;
  logic [CW-1:0]   den_reg;
  logic [CW-1:0]   rem_reg;
  logic [NW-1:0]   q_reg;
  logic [CNTW-1:0] cnt_reg;
  logic            sign_reg;
  logic            neg_reg;
  logic            dzero_reg;
  logic [DW-1:0]   quotient_reg;
  logic            ovf_reg;
  logic            dz_reg;

  logic [CW:0]     rem_shift;
  logic [CW:0]     rem_sub;
  logic            step_ge;
  logic [CW-1:0]   rem_step;

  logic            round_up;
  logic [NW:0]     mag_round;
  logic [NW:0]     limit;
  logic            sat;
  logic [DW-1:0]   mag_sat;
  logic [DW-1:0]   q_fix;

  sign_mag #(.W(DW)) u_dividend_sm (
    .value (dividend),
    .sign  (sign_a),
    .mag   (mag_a)
  );

  sign_mag #(.W(CW)) u_divisor_sm (
    .value (divisor),
    .sign  (sign_b),
    .mag   (mag_b)
  );

  // One restoring step: bring in the next numerator bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_reg, num_reg[NW-1]};
    rem_sub   = rem_shift - {1'b0, den_reg};
    step_ge   = (rem_shift >= {1'b0, den_reg});
    rem_step  = step_ge ? rem_sub[CW-1:0] : rem_shift[CW-1:0];
  end

  // Final fix-up: optional rounding, saturation to the signed range, then sign.
  always_comb begin
`ifdef FIXDIV_ROUND_EN
    round_up = ({rem_reg, 1'b0} >= {1'b0, den_reg});
`else
    round_up = 1'b0;
`endif
    mag_round = {1'b0, q_reg} + {{NW{1'b0}}, round_up};
    limit     = sign_reg ? NEG_MAG : POS_MAX;
    sat       = (mag_round > limit);
    mag_sat   = sat ? limit[DW-1:0] : mag_round[DW-1:0];
    // Negating zero yields zero, so no negative-zero case exists.
    q_fix     = sign_reg ? ({DW{1'b0}} - mag_sat) : mag_sat;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid)              state_next = CALC;
      CALC: if (cnt_reg == '0)         state_next = FIX;
      FIX:                             state_next = DONE;
      DONE: if (out_ready)             state_next = IDLE;
      default:                         state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  // Datapath: operand capture, iterative division and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_reg      <= '0;
      den_reg      <= '0;
      rem_reg      <= '0;
      q_reg        <= '0;
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      neg_reg      <= 1'b0;
      dzero_reg    <= 1'b0;
      quotient_reg <= '0;
      ovf_reg      <= 1'b0;
      dz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            num_reg   <= {mag_a, {FRAC{1'b0}}};
            den_reg   <= mag_b;
            rem_reg   <= '0;
            q_reg     <= '0;
            cnt_reg   <= CNTW'(NW - 1);
            sign_reg  <= sign_a ^ sign_b;
            neg_reg   <= sign_a;
            dzero_reg <= (divisor == '0);
          end
        end
        CALC: begin
          rem_reg <= rem_step;
          num_reg <= {num_reg[NW-2:0], 1'b0};
          q_reg   <= {q_reg[NW-2:0], step_ge};
          cnt_reg <= cnt_reg - 1'b1;
        end
        FIX: begin
          if (dzero_reg) begin
            quotient_reg <= neg_reg ? NEG_MAG[DW-1:0] : POS_MAX[DW-1:0];
            ovf_reg      <= 1'b0;
            dz_reg       <= 1'b1;
          end else begin
            quotient_reg <= q_fix;
            ovf_reg      <= sat;
            dz_reg       <= 1'b0;
          end
        end
        default: ; // DONE: result held until accepted
      endcase
    end
  end

  assign quotient = quotient_reg;
  assign ovf      = ovf_reg;
  assign dz       = dz_reg;

endmodule

// File: tb/tb_fixdiv17.sv
// Self-checking bench for fixdiv17: scoreboard of expected results built from an
// integer reference model, compared when each result is handed off.
module tb_fixdiv17;

  typedef struct packed {
    logic [16:0] q;
    logic        ovf;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] quotient;
  logic        ovf;
  logic        dz;

  int checks = 0;
  int passed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fixdiv17 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .ovf       (ovf),
    .dz        (dz)
  );

  // Reference: signed integer division of dividend*128 by divisor.
  function automatic exp_t model(input logic [16:0] a, input logic [7:0] b);
    exp_t   e;
    longint n, d, q, r, ar, ad;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    n = longint'($signed(a)) * 128;
    if (b == 8'd0) begin
      e.dz = 1'b1;
      q = a[16] ? -65536 : 65535;
    end else begin
      d = longint'($signed(b));
      q = n / d;
      r = n % d;
`ifdef FIXDIV_ROUND_EN
      ar = (r < 0) ? -r : r;
      ad = (d < 0) ? -d : d;
      if (2 * ar >= ad) q = ((n < 0) != (d < 0)) ? q - 1 : q + 1;
`else
      ar = r; ad = d;
`endif
      if (q > 65535)  begin q = 65535;  e.ovf = 1'b1; end
      if (q < -65536) begin q = -65536; e.ovf = 1'b1; end
    end
    e.q = q[16:0];
    return e;
  endfunction

  // Drive one operation, wait for the result (bounded), hand it off.
  task automatic run_op(input logic [16:0] a, input logic [7:0] b,
                        output logic [16:0] q, output logic o, output logic z,
                        output int lat);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    sb.push_back(model(a, b));
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    q = quotient; o = ovf; z = dz;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
    checks++; if ({quotient, ovf, dz} !== 19'd0) $display("FAIL reset_outputs got q=%h ovf=%b dz=%b exp 0", quotient, ovf, dz); else passed++;
    rst = 1'b0;
    $display("reset: in_ready=%b out_valid=%b q=%h", in_ready, out_valid, quotient);
  endtask

  task automatic test_arith;
    logic [16:0] va[10];
    logic [7:0]  vb[10];
    logic [16:0] q; logic o, z; int lat; exp_t e;
    va = '{17'd1000, 17'h1FC18, 17'd1000, 17'd65535, 17'h10000, 17'd5, 17'h1FFFB, 17'd0, 17'h10000, 17'd0};
    vb = '{8'd64,    8'd64,     8'h80,    8'd1,      8'd1,      8'd0,  8'd0,      8'h80, 8'h80,     8'd0};
    for (int i = 0; i < 10; i++) begin
      run_op(va[i], vb[i], q, o, z, lat);
      e = sb.pop_front();
      $display("arith[%0d]: a=%h b=%h q=%h ovf=%b dz=%b lat=%0d exp q=%h ovf=%b dz=%b",
               i, va[i], vb[i], q, o, z, lat, e.q, e.ovf, e.dz);
      checks++; if (q !== e.q)   $display("FAIL arith_q[%0d] got=%h exp=%h", i, q, e.q); else passed++;
      checks++; if (o !== e.ovf) $display("FAIL arith_ovf[%0d] got=%b exp=%b", i, o, e.ovf); else passed++;
      checks++; if (z !== e.dz)  $display("FAIL arith_dz[%0d] got=%b exp=%b", i, z, e.dz); else passed++;
      checks++; if (lat != 25)   $display("FAIL arith_latency[%0d] got=%0d exp=25", i, lat); else passed++;
    end
  endtask

  task automatic test_round;
    logic [16:0] q; logic o, z; int lat; exp_t e;
    logic [16:0] exp_pos, exp_neg;
`ifdef FIXDIV_ROUND_EN
    exp_pos = 17'd43; exp_neg = 17'h1FFD5;
`else
    exp_pos = 17'd42; exp_neg = 17'h1FFD6;
`endif
    run_op(17'd1, 8'd3, q, o, z, lat);
    e = sb.pop_front();
    $display("round: a=1 b=3 q=%h exp=%h", q, exp_pos);
    checks++; if (q !== exp_pos) $display("FAIL round_pos got=%h exp=%h", q, exp_pos); else passed++;
    checks++; if (q !== e.q) $display("FAIL round_pos_model got=%h exp=%h", q, e.q); else passed++;
    run_op(17'h1FFFF, 8'd3, q, o, z, lat);
    e = sb.pop_front();
    $display("round: a=-1 b=3 q=%h exp=%h", q, exp_neg);
    checks++; if (q !== exp_neg) $display("FAIL round_neg got=%h exp=%h", q, exp_neg); else passed++;
    checks++; if (q !== e.q) $display("FAIL round_neg_model got=%h exp=%h", q, e.q); else passed++;
  endtask

  task automatic test_random;
    logic [16:0] a, q; logic [7:0] b; logic o, z; int lat; exp_t e;
    for (int i = 0; i < 10; i++) begin
      a = 17'($urandom);
      b = 8'($urandom);
      run_op(a, b, q, o, z, lat);
      e = sb.pop_front();
      $display("random[%0d]: a=%h b=%h q=%h ovf=%b dz=%b exp q=%h ovf=%b dz=%b",
               i, a, b, q, o, z, e.q, e.ovf, e.dz);
      checks++;
      if ({q, o, z} !== {e.q, e.ovf, e.dz})
        $display("FAIL random[%0d] got q=%h ovf=%b dz=%b exp q=%h ovf=%b dz=%b", i, q, o, z, e.q, e.ovf, e.dz);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [16:0] q; logic o, z; int lat; exp_t e;
    run_op(17'd300, 8'd32, q, o, z, lat);
    e = sb.pop_front();
    checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", in_ready); else passed++;
    checks++; if (q !== e.q) $display("FAIL b2b_q0 got=%h exp=%h", q, e.q); else passed++;
    run_op(17'h1FED4, 8'd127, q, o, z, lat);
    e = sb.pop_front();
    $display("b2b: second q=%h exp=%h lat=%0d", q, e.q, lat);
    checks++; if (q !== e.q) $display("FAIL b2b_q1 got=%h exp=%h", q, e.q); else passed++;
    checks++; if (lat != 25) $display("FAIL b2b_latency got=%0d exp=25", lat); else passed++;
  endtask

  task automatic test_backpressure;
    logic [16:0] hold; exp_t e; int w; bit ok;
    @(negedge clk);
    sb.push_back(model(17'd1000, 8'd64));
    in_valid = 1'b1; dividend = 17'd1000; divisor = 8'd64;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin @(negedge clk); w++; end
    hold = quotient;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; dividend = 17'd7; divisor = 8'd1;
      @(negedge clk);
      if (quotient !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (!ok) $display("FAIL bp_hold q=%h held=%h in_ready=%b out_valid=%b", quotient, hold, in_ready, out_valid); else passed++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    e = sb.pop_front();
    $display("backpressure: q=%h exp=%h in_ready=%b out_valid=%b", hold, e.q, in_ready, out_valid);
    checks++; if (hold !== e.q) $display("FAIL bp_q got=%h exp=%h", hold, e.q); else passed++;
    checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", in_ready); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    bit rose;
    @(negedge clk);
    in_valid = 1'b1; dividend = 17'd1234; divisor = 8'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("reset_mid: in_ready=%b out_valid=%b q=%h ovf=%b dz=%b", in_ready, out_valid, quotient, ovf, dz);
    checks++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got=%b exp=1", in_ready); else passed++;
    checks++; if ({out_valid, quotient, ovf, dz} !== 20'd0) $display("FAIL rmid_outputs got v=%b q=%h ovf=%b dz=%b exp 0", out_valid, quotient, ovf, dz); else passed++;
    rose = 1'b0;
    repeat (30) begin @(negedge clk); if (out_valid) rose = 1'b1; end
    checks++; if (rose) $display("FAIL rmid_no_result got out_valid=1 exp never"); else passed++;
  endtask

  initial begin
    test_reset;
    test_arith;
    test_round;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/fixdiv17.md
Name: fixdiv17

Overview:
- Sequential fixed-point divider. It is the inverse of the butterfly's 17-bit × Q1.7 coefficient multiplier.
- Given a 17-bit two's-complement product and the 8-bit Q1.7 coefficient, it recovers the operand: quotient = trunc(dividend·2^FRAC / divisor).
- Used by the IFFT/normalisation path to undo coefficient scaling.
- Valid/ready on both sides. One division in flight.

Parameters:
- DW, 17, dividend/quotient width (two's complement).
- CW, 8, divisor width (two's complement, Q1.(CW-1)).
- FRAC, 7, divisor fraction bits; numerator is pre-shifted left by FRAC.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept a new operation.
- dividend  in  DW  signed numerator.
- divisor  in  CW  signed Q1.7 coefficient.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  DW  signed result, saturated.
- ovf  out  1  result saturated (magnitude exceeded range); valid with out_valid.
- dz  out  1  divisor was zero; valid with out_valid.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, ovf=0, dz=0. All internal registers are cleared.
- Reset mid-operation: rst in any state aborts the operation. The next cycle is IDLE with reset values and the result is discarded.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge k, latch the following, then go to CALC with bit counter = DW+FRAC-1:
    - sign = dividend[DW-1] XOR divisor[CW-1];
    - num = |dividend| << FRAC (DW+FRAC=24 bits);
    - den = |divisor| (CW bits; |−128| = 128);
    - dzero = (divisor==0);
    - clear the remainder.
  - CALC: in_ready=0. Perform one restoring-division step per cycle, MSB first:
    - rem = {rem, num bit};
    - if rem >= den then rem -= den and q bit = 1;
    - after the bit-0 step (edge k+24), go to FIX.
  - FIX: apply the rounding option, then saturation and sign:
    - magnitude limit = 2^(DW-1)-1 (65535) when positive, 2^(DW-1) (65536) when negative;
    - if mag > limit, clamp to the limit and ovf=1;
    - quotient = sign ? −mag : mag;
    - if dzero: skip the division result, quotient = 65535 (dividend ≥ 0) or −65536 (dividend < 0), dz=1, ovf=0;
    - out_valid=1 after edge k+25; go to DONE.
  - DONE: quotient/ovf/dz are held stable while out_valid && !out_ready. On out_valid&&out_ready: out_valid=0, in_ready=1, go to IDLE. The next input is accepted no earlier than the following cycle.
- Latency: 25 clock edges from the accept edge to out_valid. Throughput is one result per ≥27 cycles.
- Zero dividend gives quotient 0, ovf=0 (no negative zero).
- Sign of result: the quotient is negated only when the operand signs differ and the magnitude is nonzero.
- Dividend −65536: magnitude 65536 is handled in the 24-bit numerator; no wrap.
- Divisor −128: den=128, exact ÷(−1.0).
- in_valid while busy is ignored (in_ready=0). The upstream holds its data.

Optional Feature:
- Macro: FIXDIV_ROUND_EN.
- Defined: FIX rounds half away from zero. If 2·rem >= den, mag += 1 before saturation. FIX stays one cycle, so latency is unchanged.
- Undefined: truncation toward zero, matching the multiplier's magnitude-truncate convention.

Decomposition:
- Package fixdiv_pkg:
  - state enum {IDLE, CALC, FIX, DONE};
  - localparams NW=DW+FRAC, CNTW=$clog2(NW);
  - saturation limit constants POS_MAX, NEG_MAG.
- Sub-module sign_mag, combinational, parameterised width: two's complement in → {sign, unsigned magnitude out}.
  - Instantiated twice, once for the dividend and once for the divisor.
  - Reusable by the multiplier path.

Test Plan:
- dividend=1000, divisor=64 (0.5) → quotient=2000, ovf=0, dz=0; out_valid exactly 25 edges after accept.
- dividend=−1000 (17'h1FC18), divisor=64 → quotient=−2000 (17'h1F830); dividend=1000, divisor=8'h80 (−1.0) → quotient=−1000.
- dividend=65535, divisor=1 → quotient=65535, ovf=1; dividend=−65536, divisor=1 → quotient=−65536 (17'h10000), ovf=1.
- divisor=0 with dividend=5 → 65535, dz=1, ovf=0; with dividend=−5 → 17'h10000, dz=1.
- Handshake and reset:
  - hold out_ready=0 for 5 cycles → quotient stable, in_ready=0, second in_valid ignored; release → in_ready=1 next cycle.
  - assert rst at CALC cycle 10 → out_valid never rises, IDLE with reset values next cycle.
- Rounding, dividend=1, divisor=3 → quotient=42 without FIXDIV_ROUND_EN, 43 with it; dividend=−1, divisor=3 → −42 / −43.
